tx_medida_seq: RTL and testbench
================================

Name: tx_medida_seq

Overview:
- Message sequencer that drives the 7O1 serial transmitter's partida/dados_ascii/pronto handshake.
- On one start pulse it latches a BCD angle and a BCD distance.
- It then sends the fixed frame "AAA,DDD#" one character at a time, waiting for transmitter pronto between characters.
- Sits between the turret measurement control and the transmitter; includes a per-character watchdog.

Parameters:
- SEP_CHAR, 7'h2C, ASCII separator between the angle and distance fields (',').
- END_CHAR, 7'h23, ASCII frame terminator ('#').
- TIMEOUT, 50000, clock cycles allowed between tx_partida and tx_pronto before abort.
- TW, 16, width of the watchdog counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- partida  in  1  start request; sampled only in INICIAL.
- angulo  in  12  3 BCD digits, [11:8] = hundreds.
- distancia  in  12  3 BCD digits, [11:8] = hundreds.
- tx_pronto  in  1  transmitter end-of-character pulse.
- tx_partida  out  1  one-cycle start pulse to the transmitter.
- tx_dados  out  7  ASCII character to the transmitter; stable from tx_partida until tx_pronto.
- ocupado  out  1  high from leaving INICIAL until returning to INICIAL.
- pronto  out  1  one-cycle pulse when the frame completes normally.
- erro  out  1  sticky watchdog flag; cleared only by the next accepted partida or by reset.
- db_indice  out  4  index of the current character.
- db_estado  out  4  FSM state code.

Behaviour:
- Reset: asynchronous, active-low (reset=0), independent of clock. State goes to INICIAL. All outputs, registers, index and watchdog go to 0; tx_dados goes to 7'h00. A reset mid-frame aborts immediately and no further tx_partida is issued.
- FSM states and codes:
  - INICIAL (0): idle. partida=1 moves to PREPARA.
  - PREPARA (1): latch angulo/distancia, clear index, clear erro.
  - ENVIA (2): tx_partida=1 for exactly one cycle; load the watchdog with 0.
  - ESPERA (3): wait for tx_pronto=1, then go to PROXIMO. When the watchdog reaches TIMEOUT-1 without tx_pronto, go to ERRO.
  - PROXIMO (4): if index = last, go to FINAL; else increment index and go to ENVIA.
  - FINAL (5): pronto=1 for one cycle, then go to INICIAL.
  - ERRO (15): set erro, then go to INICIAL the next cycle; pronto is not pulsed.
- Timing:
  - Latency is 2 cycles from partida sampled high to tx_partida high.
  - Inter-character gap is 2 cycles from tx_pronto to the next tx_partida.
- Character map, by index:
  - 0..2: angle digits, hundreds first.
  - 3: SEP_CHAR.
  - 4..6: distance digits, hundreds first.
  - 7: END_CHAR.
  - Last index is 7.
- Digit encoding:
  - BCD nibble 0..9 maps to 7'h30 + d.
  - Nibbles 10..15 map to 7'h3F ('?').
- tx_dados is registered and updated in PREPARA/PROXIMO, so it is valid one cycle before tx_partida.
- Input and handshake rules:
  - Inputs are latched once; changes during a frame are ignored.
  - partida while ocupado=1 is ignored and not queued.
  - tx_pronto outside ESPERA is ignored.
  - tx_pronto in the same cycle the watchdog expires: tx_pronto wins and the frame proceeds.
  - partida held high continuously starts a new frame one cycle after FINAL/ERRO returns to INICIAL.
- Watchdog: counts only in ESPERA and saturates at TIMEOUT-1.

Optional Feature:
- Macro: TX_MEDIDA_SEQ_CRLF_EN.
- When defined, two characters follow END_CHAR: index 8 = 7'h0D (CR) and index 9 = 7'h0A (LF). Last index is 9 and a frame is 10 characters.
- When undefined, the frame is 8 characters and last index is 7.
- db_indice stays 4 bits in both builds.

Decomposition:
- Package tx_medida_pkg holds:
  - the state encodings (4-bit localparams listed above);
  - ASCII constants ZERO=7'h30, INVALID=7'h3F, CR, LF;
  - frame-length constants for both builds.
- One natural sub-module: tx_medida_char_sel, combinational index + latched fields → 7-bit ASCII, including the BCD-to-ASCII and invalid-digit mapping.
- FSM, index counter and watchdog stay in the top module.

Test Plan:
- Full frame: angulo=12'h045, distancia=12'h123, transmitter model returns pronto 20 cycles after each partida. Expect tx_dados sequence 30,34,35,2C,31,32,33,23 (hex), one tx_partida per character, pronto pulse once, ocupado low after FINAL.
- Invalid digit: angulo=12'h0A9. Expect the second character 7'h3F and the rest normal.
- Busy/latch: pulse partida again at character 3 and change distancia to 12'h999 mid-frame. Expect no restart and distance characters still 31,32,33.
- Watchdog: TIMEOUT=100, model never asserts tx_pronto. Expect ERRO after 100 cycles in ESPERA, erro=1, no pronto, back in INICIAL; next partida clears erro.
- Reset mid-frame: drive reset=0 asynchronously (between clock edges) during character 5. Expect all outputs 0 immediately and no tx_partida until a new partida after release.
- CRLF build: with TX_MEDIDA_SEQ_CRLF_EN defined, expect 10 characters ending 23,0D,0A and db_indice reaching 9.

Source files
------------

// File: rtl/tx_medida_pkg.sv
// tx_medida_seq shared types and constants.
// Frame length depends on TX_MEDIDA_SEQ_CRLF_EN.
package tx_medida_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL = 4'd0,
    ST_PREPARA = 4'd1,
    ST_ENVIA   = 4'd2,
    ST_ESPERA  = 4'd3,
    ST_PROXIMO = 4'd4,
    ST_FINAL   = 4'd5,
    ST_ERRO    = 4'd15
  } estado_t;

  localparam logic [6:0] ZERO    = 7'h30;
  localparam logic [6:0] INVALID = 7'h3F;
  localparam logic [6:0] CR      = 7'h0D;
  localparam logic [6:0] LF      = 7'h0A;

  localparam int FRAME_LEN_BASE = 8;
  localparam int FRAME_LEN_CRLF = 10;

  localparam logic [3:0] LAST_BASE = 4'd7;
  localparam logic [3:0] LAST_CRLF = 4'd9;

  function automatic logic [6:0] bcd2ascii(
    input logic [3:0] d
  );
    logic [6:0] c;
    if (d <= 4'd9)
      c = ZERO + {3'b000, d};
    else
      c = INVALID;
    return c;
  endfunction

endpackage

// File: rtl/tx_medida_char_sel.sv
// Character selector: frame index + fields -> ASCII.
// CR/LF slots exist only with TX_MEDIDA_SEQ_CRLF_EN.
module tx_medida_char_sel
  import tx_medida_pkg::*;
#(
  parameter logic [6:0] SEP_CHAR = 7'h2C,
  parameter logic [6:0] END_CHAR = 7'h23
) (
  input  logic [3:0]  i_indice,
  input  logic [11:0] i_angulo,
  input  logic [11:0] i_distancia,
  output logic [6:0]  o_char
);

  // map frame slot to its character
  always_comb begin
    o_char = 7'h00;
    case (i_indice)
      4'd0: o_char = bcd2ascii(i_angulo[11:8]);
      4'd1: o_char = bcd2ascii(i_angulo[7:4]);
      4'd2: o_char = bcd2ascii(i_angulo[3:0]);
      4'd3: o_char = SEP_CHAR;
      4'd4: o_char = bcd2ascii(i_distancia[11:8]);
      4'd5: o_char = bcd2ascii(i_distancia[7:4]);
      4'd6: o_char = bcd2ascii(i_distancia[3:0]);
      4'd7: o_char = END_CHAR;
`ifdef TX_MEDIDA_SEQ_CRLF_EN
      4'd8: o_char = CR;
      4'd9: o_char = LF;
`endif
      default: o_char = 7'h00;
    endcase
  end

endmodule

// File: rtl/tx_medida_seq.sv
// Frame sequencer "AAA,DDD#" for the 7O1 transmitter.
// Define TX_MEDIDA_SEQ_CRLF_EN to append CR LF.
module tx_medida_seq
  import tx_medida_pkg::*;
#(
  parameter logic [6:0] SEP_CHAR = 7'h2C,
  parameter logic [6:0] END_CHAR = 7'h23,
  parameter int         TIMEOUT  = 50000,
  parameter int         TW       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  input  logic        tx_pronto,
  output logic        tx_partida,
  output logic [6:0]  tx_dados,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_indice,
  output logic [3:0]  db_estado
);

`ifdef TX_MEDIDA_SEQ_CRLF_EN
  localparam logic [3:0] LAST_IDX = LAST_CRLF;
`else
  localparam logic [3:0] LAST_IDX = LAST_BASE;
`endif

  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT - 1);

  estado_t       r_estado;
  logic [3:0]    r_indice;
  logic [TW-1:0] r_wd;
  logic [11:0]   r_ang;
  logic [11:0]   r_dist;
  logic          r_tx_partida;
  logic [6:0]    r_tx_dados;
  logic          r_ocupado;
  logic          r_pronto;
  logic          r_erro;

  logic [3:0]    w_sel_idx;
  logic [11:0]   w_sel_ang;
  logic [11:0]   w_sel_dist;
  logic [6:0]    w_char;

  // next character: slot 0 of live inputs when idle, else slot idx+1
  always_comb begin
    w_sel_idx  = 4'd0;
    w_sel_ang  = angulo;
    w_sel_dist = distancia;
    if (r_estado != ST_INICIAL) begin
      w_sel_idx  = r_indice + 4'd1;
      w_sel_ang  = r_ang;
      w_sel_dist = r_dist;
    end
  end

  tx_medida_char_sel #(
    .SEP_CHAR (SEP_CHAR),
    .END_CHAR (END_CHAR)
  ) u_char_sel (
    .i_indice    (w_sel_idx),
    .i_angulo    (w_sel_ang),
    .i_distancia (w_sel_dist),
    .o_char      (w_char)
  );

  // sequencer FSM, index, watchdog and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= ST_INICIAL;
      r_indice     <= 4'd0;
      r_wd         <= '0;
      r_ang        <= 12'h000;
      r_dist       <= 12'h000;
      r_tx_partida <= 1'b0;
      r_tx_dados   <= 7'h00;
      r_ocupado    <= 1'b0;
      r_pronto     <= 1'b0;
      r_erro       <= 1'b0;
    end else begin
      r_tx_partida <= 1'b0;
      r_pronto     <= 1'b0;
      case (r_estado)
        ST_INICIAL: begin
          if (partida) begin
            r_estado   <= ST_PREPARA;
            r_ang      <= angulo;
            r_dist     <= distancia;
            r_indice   <= 4'd0;
            r_erro     <= 1'b0;
            r_tx_dados <= w_char;
            r_ocupado  <= 1'b1;
          end
        end
        ST_PREPARA: begin
          r_estado     <= ST_ENVIA;
          r_tx_partida <= 1'b1;
        end
        ST_ENVIA: begin
          r_estado <= ST_ESPERA;
          r_wd     <= '0;
        end
        ST_ESPERA: begin
          if (tx_pronto) begin
            r_estado <= ST_PROXIMO;
            // preload so the character leads tx_partida by a cycle
            if (r_indice != LAST_IDX)
              r_tx_dados <= w_char;
          end else if (r_wd == WD_MAX) begin
            r_estado <= ST_ERRO;
            r_erro   <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_PROXIMO: begin
          if (r_indice == LAST_IDX) begin
            r_estado <= ST_FINAL;
            r_pronto <= 1'b1;
          end else begin
            r_indice     <= r_indice + 4'd1;
            r_estado     <= ST_ENVIA;
            r_tx_partida <= 1'b1;
          end
        end
        ST_FINAL: begin
          r_estado  <= ST_INICIAL;
          r_ocupado <= 1'b0;
        end
        ST_ERRO: begin
          r_estado  <= ST_INICIAL;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= ST_INICIAL;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign tx_partida = r_tx_partida;
  assign tx_dados   = r_tx_dados;
  assign ocupado    = r_ocupado;
  assign pronto     = r_pronto;
  assign erro       = r_erro;
  assign db_indice  = r_indice;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_tx_medida_seq.sv
// Bench for tx_medida_seq: table vectors, random frames,
// watchdog, busy, reset and held-start sequences.
module tb_tx_medida_seq;

`ifdef TX_MEDIDA_SEQ_CRLF_EN
  localparam int NCH   = 10;
  localparam int LASTI = 9;
`else
  localparam int NCH   = 8;
  localparam int LASTI = 7;
`endif
  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        partida = 1'b0;
  logic [11:0] angulo = 12'h000;
  logic [11:0] distancia = 12'h000;
  logic        tx_pronto = 1'b0;
  logic        tx_partida;
  logic [6:0]  tx_dados;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_indice;
  logic [3:0]  db_estado;

  tx_medida_seq #(
    .TIMEOUT (TO),
    .TW      (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .partida    (partida),
    .angulo     (angulo),
    .distancia  (distancia),
    .tx_pronto  (tx_pronto),
    .tx_partida (tx_partida),
    .tx_dados   (tx_dados),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .erro       (erro),
    .db_indice  (db_indice),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // transmitter model / monitor state (written only by the monitor)
  int         cyc = 0;
  int         cnt = 0;
  logic [6:0] cap[$];
  int         tx_cyc[$];
  logic [6:0] held = 7'h00;
  bit         waiting = 0;
  int         n_pronto = 0;
  int         gap_bad = 0;
  int         stab_bad = 0;
  int         last_pr = -1;
  int         max_idx = 0;

  // written only by the stimulus process
  int pronto_delay = 20;
  int b_cap, b_pronto, b_gap, b_stab;
  int erro_cyc;

  typedef struct {
    logic [11:0] a;
    logic [11:0] d;
    int          dly;
    logic [6:0]  e [8];
  } vec_t;

  vec_t tv [4];

  // transmitter: answers each tx_partida with a pronto after a delay
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      tx_pronto = 1'b0;
      cnt = 0;
      waiting = 0;
      last_pr = -1;
    end else begin
      if (tx_partida) begin
        cap.push_back(tx_dados);
        tx_cyc.push_back(cyc);
        held = tx_dados;
        waiting = 1;
        if (last_pr >= 0 && cyc - last_pr != 2) gap_bad++;
        cnt = pronto_delay;
      end else if (waiting && tx_dados !== held) begin
        stab_bad++;
      end
      if (pronto) begin
        n_pronto++;
        last_pr = -1;
      end
      if (int'(db_indice) > max_idx) max_idx = int'(db_indice);
      tx_pronto = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_pronto = 1'b1;
          waiting = 0;
          last_pr = cyc;
        end
      end
    end
  end

  function automatic logic [6:0] ref_char(
    input logic [11:0] a, input logic [11:0] d, input int i
  );
    logic [11:0] f;
    int n;
    if (i == 3) return 7'h2C;
    if (i == 7) return 7'h23;
    if (i == 8) return 7'h0D;
    if (i == 9) return 7'h0A;
    f = (i < 3) ? a : d;
    n = int'((f >> (4 * (2 - (i % 4)))) & 12'hF);
    if (n < 10) return 7'(48 + n);
    return 7'(63);
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic run_frame(
    input logic [11:0] a, input logic [11:0] d,
    input int dly, input int mode
  );
    bit done;
    bit dist_done;
    done = 0;
    dist_done = 0;
    erro_cyc = -1;
    b_cap = cap.size();
    b_pronto = n_pronto;
    b_gap = gap_bad;
    b_stab = stab_bad;
    pronto_delay = dly;
    angulo = a;
    distancia = d;
    @(negedge clock); #1;
    partida = 1'b1;
    @(negedge clock); #1;
    partida = 1'b0;
    chk("prep_state", db_estado, 1);
    chk("prep_ocupado", ocupado, 1);
    chk("prep_erro_clr", erro, 0);
    chk("prep_dados", tx_dados, ref_char(a, d, 0));
    @(negedge clock); #1;
    chk("latency_tx_partida", tx_partida, 1);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock); #1;
      if (db_estado == 4'hF && erro_cyc < 0) erro_cyc = cyc;
      if (mode == 1) begin
        if (cap.size() - b_cap == 4 && !dist_done) begin
          partida = 1'b1;
          distancia = 12'h999;
          dist_done = 1;
        end else begin
          partida = 1'b0;
        end
      end
      if (mode == 2 && cap.size() - b_cap == 6) begin
        done = 1;
        break;
      end
      if (!ocupado) begin
        done = 1;
        break;
      end
    end
    partida = 1'b0;
    chk("frame_in_budget", done, 1);
  endtask

  task automatic frame_checks(
    input string nm, input logic [6:0] ex [10],
    input int n, input int npr, input logic er
  );
    longint got;
    for (int i = 0; i < n; i++) begin
      got = (b_cap + i < cap.size()) ? longint'(cap[b_cap + i]) : -1;
      chk($sformatf("%s_char%0d", nm, i), got, ex[i]);
    end
    chk({nm, "_nchars"}, cap.size() - b_cap, n);
    chk({nm, "_pronto"}, n_pronto - b_pronto, npr);
    chk({nm, "_erro"}, erro, er);
    chk({nm, "_ocupado"}, ocupado, 0);
    chk({nm, "_gap"}, gap_bad - b_gap, 0);
    chk({nm, "_stable"}, stab_bad - b_stab, 0);
  endtask

  logic [6:0]  ex [10];
  logic [11:0] ra, rd;
  int          ncap;
  bit          seen;

  initial begin
    tv[0] = '{12'h045, 12'h123, 20,
      '{7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23}};
    tv[1] = '{12'h0A9, 12'h123, 7,
      '{7'h30, 7'h3F, 7'h39, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23}};
    tv[2] = '{12'h999, 12'h000, 2,
      '{7'h39, 7'h39, 7'h39, 7'h2C, 7'h30, 7'h30, 7'h30, 7'h23}};
    tv[3] = '{12'hFFF, 12'h5B7, 101,
      '{7'h3F, 7'h3F, 7'h3F, 7'h2C, 7'h35, 7'h3F, 7'h37, 7'h23}};

    repeat (3) @(negedge clock);
    #1;
    chk("rst_tx_partida", tx_partida, 0);
    chk("rst_tx_dados", tx_dados, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_erro", erro, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_indice", db_indice, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 10; i++)
        ex[i] = (i < 8) ? tv[t].e[i] : ref_char(tv[t].a, tv[t].d, i);
      run_frame(tv[t].a, tv[t].d, tv[t].dly, 0);
      frame_checks($sformatf("tab%0d", t), ex, NCH, 1, 1'b0);
    end
    chk("max_indice", max_idx, LASTI);

    for (int r = 0; r < 4; r++) begin
      ra = 12'($urandom);
      rd = 12'($urandom);
      for (int i = 0; i < 10; i++) ex[i] = ref_char(ra, rd, i);
      run_frame(ra, rd, int'($urandom_range(30, 2)), 0);
      frame_checks($sformatf("rnd%0d", r), ex, NCH, 1, 1'b0);
    end

    for (int i = 0; i < 10; i++) ex[i] = ref_char(12'h321, 12'h123, i);
    run_frame(12'h321, 12'h123, 12, 1);
    frame_checks("busy", ex, NCH, 1, 1'b0);
    ncap = cap.size();
    repeat (5) @(negedge clock);
    #1;
    chk("busy_not_queued_ocupado", ocupado, 0);
    chk("busy_not_queued_tx", cap.size(), ncap);

    for (int i = 0; i < 10; i++) ex[i] = ref_char(12'h045, 12'h123, i);
    run_frame(12'h045, 12'h123, 0, 0);
    frame_checks("wdog", ex, 1, 0, 1'b1);
    chk("wdog_estado", db_estado, 0);
    chk("wdog_espera_len",
        (cap.size() > b_cap && erro_cyc >= 0) ?
          erro_cyc - tx_cyc[b_cap] : -1,
        TO + 1);

    for (int i = 0; i < 10; i++) ex[i] = ref_char(12'h045, 12'h123, i);
    run_frame(12'h045, 12'h123, 20, 0);
    frame_checks("after_wdog", ex, NCH, 1, 1'b0);

    run_frame(12'h246, 12'h135, 9, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_tx_partida", tx_partida, 0);
    chk("arst_tx_dados", tx_dados, 0);
    chk("arst_ocupado", ocupado, 0);
    chk("arst_pronto", pronto, 0);
    chk("arst_erro", erro, 0);
    chk("arst_estado", db_estado, 0);
    chk("arst_indice", db_indice, 0);
    ncap = cap.size();
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("arst_no_tx", cap.size(), ncap);
    for (int i = 0; i < 10; i++) ex[i] = ref_char(12'h246, 12'h135, i);
    run_frame(12'h246, 12'h135, 9, 0);
    frame_checks("after_rst", ex, NCH, 1, 1'b0);

    ncap = cap.size();
    pronto_delay = 3;
    angulo = 12'h777;
    distancia = 12'h888;
    partida = 1'b1;
    seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock); #1;
      if (pronto) begin
        seen = 1;
        break;
      end
    end
    chk("held_first_done", seen, 1);
    @(negedge clock); #1;
    chk("held_idle_cycle", db_estado, 0);
    @(negedge clock); #1;
    chk("held_restart", db_estado, 1);
    partida = 1'b0;
    seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock); #1;
      if (!ocupado) begin
        seen = 1;
        break;
      end
    end
    chk("held_second_done", seen, 1);
    chk("held_nchars", cap.size() - ncap, 2 * NCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
